decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 28 ++
 rtl/decode_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// decode_queue_if: producer/consumer handshake, flush and occupancy bundle for decode_queue.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 11,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [ID_W-1:0] out_id;
  logic            out_ri;
  logic            flush;
  logic [CW-1:0]   count;
  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, out_id, out_ri, count
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, out_id, out_ri, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: FIFO of MIPS words decoded at push; IDs 1..54 follow the alphabetical
// mnemonic order, 100 = unknown. Optional macro DECODE_QUEUE_RI_EN stores a reserved-instruction flag.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 11,
  parameter int PC_W  = 32
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instr [DEPTH];
  logic [PC_W-1:0] r_pc    [DEPTH];
  logic [ID_W-1:0] r_id    [DEPTH];
  logic            w_push, w_pop;
  logic [ID_W-1:0] w_dec;

  function automatic logic [ID_W-1:0] decode(input logic [31:0] w);
    logic [6:0] id;
    id = 7'd100;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00: id = 7'd40;
        6'h02: id = 7'd48;
        6'h03: id = 7'd46;
        6'h04: id = 7'd41;
        6'h06: id = 7'd49;
        6'h07: id = 7'd47;
        6'h08: id = 7'd20;
        6'h09: id = 7'd19;
        6'h0D: id = 7'd13;
        6'h10: id = 7'd28;
        6'h11: id = 7'd31;
        6'h12: id = 7'd29;
        6'h13: id = 7'd32;
        6'h18: id = 7'd33;
        6'h19: id = 7'd34;
        6'h1A: id = 7'd14;
        6'h1B: id = 7'd15;
        6'h20: id = 7'd1;
        6'h21: id = 7'd4;
        6'h22: id = 7'd50;
        6'h23: id = 7'd51;
        6'h24: id = 7'd5;
        6'h25: id = 7'd36;
        6'h26: id = 7'd53;
        6'h27: id = 7'd35;
        6'h2A: id = 7'd42;
        6'h2B: id = 7'd45;
        default: ;
      endcase
      6'h01: id = w[20:16] == 5'd0 ? 7'd11 : w[20:16] == 5'd1 ? 7'd8 : 7'd100;
      6'h02: id = 7'd17;
      6'h03: id = 7'd18;
      6'h04: id = 7'd7;
      6'h05: id = 7'd12;
      6'h06: id = 7'd10;
      6'h07: id = 7'd9;
      6'h08: id = 7'd2;
      6'h09: id = 7'd3;
      6'h0A: id = 7'd43;
      6'h0B: id = 7'd44;
      6'h0C: id = 7'd6;
      6'h0D: id = 7'd37;
      6'h0E: id = 7'd54;
      6'h0F: id = 7'd25;
      // COP0: eret is an exact word, mfc0/mtc0 are selected by rs
      6'h10: id = w == 32'h4200_0018 ? 7'd16 : w[25:21] == 5'd0 ? 7'd27 :
                  w[25:21] == 5'd4 ? 7'd30 : 7'd100;
      6'h20: id = 7'd21;
      6'h21: id = 7'd23;
      6'h23: id = 7'd26;
      6'h24: id = 7'd22;
      6'h25: id = 7'd24;
      6'h28: id = 7'd38;
      6'h29: id = 7'd39;
      6'h2B: id = 7'd52;
      default: ;
    endcase
    return ID_W'(id);
  endfunction

  assign w_dec       = decode(q.in_instr);
  assign q.in_ready  = r_count < CW'(DEPTH);
  assign q.out_valid = r_count != '0;
  assign q.count     = r_count;
  assign w_push      = q.in_valid && q.in_ready && !q.flush;
  assign w_pop       = q.out_valid && q.out_ready && !q.flush;
  assign q.out_instr = r_instr[r_rp];
  assign q.out_pc    = r_pc[r_rp];
  assign q.out_id    = r_id[r_rp];

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= q.in_instr;
      r_pc[r_wp]    <= q.in_pc;
      r_id[r_wp]    <= w_dec;
    end
  end

`ifdef DECODE_QUEUE_RI_EN
  logic r_ri [DEPTH];
  always_ff @(posedge clk) begin
    if (w_push) r_ri[r_wp] <= w_dec == ID_W'(100);
  end
  assign q.out_ri = r_ri[r_rp];
`else
  assign q.out_ri = 1'b0;
`endif
endmodule
